// File: rtl/syscall_controller_pkg.sv
// ---------------------------------------------------------------------------
// syscall_controller_pkg
// Shared definitions for the syscall sequencer: service codes, console item
// kinds, FSM state encoding and a small byte zero-extension helper.
// ---------------------------------------------------------------------------
package syscall_controller_pkg;

    // Service codes carried in $v0
    localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
    localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
    localparam logic [31:0] SYS_EXIT       = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

    // Console item kinds
    localparam logic [1:0] KIND_INT  = 2'd0;
    localparam logic [1:0] KIND_CHAR = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INT_OUT  = 3'd1,
        ST_STR_REQ  = 3'd2,
        ST_STR_WAIT = 3'd3,
        ST_STR_OUT  = 3'd4,
        ST_DONE     = 3'd5,
        ST_HALTED   = 3'd6
    } state_t;

    function automatic logic [31:0] zext_byte(input logic [7:0] b);
        return {24'b0, b};
    endfunction

endpackage

// File: rtl/syscall_controller_str_fetch.sv
// ---------------------------------------------------------------------------
// syscall_controller_str_fetch
// Owns the string address register, the emitted-byte counter and the
// mem_req/mem_ack handshake for print-string. Hands each fetched byte to the
// parent FSM and flags the end of the string (NUL byte or MAX_STR reached).
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   load, load_addr : start a new string at load_addr, counter cleared
//   req_phase       : parent is in its request state
//   wait_phase      : parent is waiting for read data
//   advance         : current byte accepted by the console, step address
//   mem_req/addr    : byte read request to data memory
//   mem_ack/rdata   : read data return
//   byte_valid      : non-NUL byte available on byte_data this cycle
//   byte_data       : returned byte
//   str_end         : string finished (limit reached or NUL returned)
// ---------------------------------------------------------------------------
module syscall_controller_str_fetch
    import syscall_controller_pkg::*;
#(
    parameter int MAX_STR = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_addr,
    input  logic        req_phase,
    input  logic        wait_phase,
    input  logic        advance,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        str_end
);

    localparam int CW = $clog2(MAX_STR + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_STR);

    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] count_q, count_d;
    logic          limit_hit;
    logic          ack_nul;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        if (load) begin
            addr_d  = load_addr;
            count_d = '0;
        end else if (advance) begin
            // address wraps naturally at 2^32
            addr_d  = addr_q + 32'd1;
            count_d = count_q + CW'(1);
        end
    end

    assign limit_hit  = (count_q == MAX_CNT);
    assign ack_nul    = (mem_rdata == 8'd0);

    // no request is issued once the limit is reached; the parent sees str_end
    assign mem_req    = (req_phase & ~limit_hit) | wait_phase;
    assign mem_addr   = addr_q;

    assign byte_valid = wait_phase & mem_ack & ~ack_nul;
    assign byte_data  = mem_rdata;
    assign str_end    = (req_phase & limit_hit) | (wait_phase & mem_ack & ack_nul);

endmodule

// File: rtl/syscall_controller.sv
// ---------------------------------------------------------------------------
// syscall_controller
// Services MIPS syscall on behalf of the pipeline: stalls it, runs the
// service chosen by $v0 (print int, print string, exit, optional print char)
// and streams results out on a ready/valid console port.
//
// Optional feature: define SYSCALL_PRINT_CHAR_EN to enable service 11
// (print the character in a0[7:0]); otherwise code 11 is treated as unknown.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for syscall_valid; v0/a0 latched on detect
// INT_OUT   | presenting latched a0 as an integer item
// STR_REQ   | issuing a byte read (or ending on MAX_STR)
// STR_WAIT  | holding mem_req until mem_ack
// STR_OUT   | presenting a character item
// DONE      | one-cycle syscall_done, pipeline released
// HALTED    | exit executed; sticky until rst
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   syscall_valid, v0,a0: syscall request from EX
//   stall, syscall_done : pipeline freeze / completion pulse
//   mem_*               : data-memory byte read port
//   out_*               : console stream (kind 0 = int, 1 = char)
//   halt                : sticky exit flag
// ---------------------------------------------------------------------------
module syscall_controller
    import syscall_controller_pkg::*;
#(
    parameter int MAX_STR = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        syscall_valid,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        stall,
    output logic        syscall_done,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_kind,
    output logic [31:0] out_data,
    output logic        halt
);

    state_t      state_q, state_d;
    logic [31:0] a0_q, a0_d;
    logic [7:0]  byte_q, byte_d;
    logic        char_mode_q, char_mode_d;

    logic        fetch_load;
    logic        fetch_advance;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        str_end;

    syscall_controller_str_fetch #(
        .MAX_STR (MAX_STR)
    ) u_str_fetch (
        .clk        (clk),
        .rst        (rst),
        .load       (fetch_load),
        .load_addr  (a0),
        .req_phase  (state_q == ST_STR_REQ),
        .wait_phase (state_q == ST_STR_WAIT),
        .advance    (fetch_advance),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .str_end    (str_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a0_q        <= '0;
            byte_q      <= '0;
            char_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a0_q        <= a0_d;
            byte_q      <= byte_d;
            char_mode_q <= char_mode_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        a0_d          = a0_q;
        byte_d        = byte_q;
        char_mode_d   = char_mode_q;
        fetch_load    = 1'b0;
        fetch_advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (syscall_valid) begin
                    a0_d        = a0;
                    char_mode_d = 1'b0;
                    case (v0)
                        SYS_PRINT_INT: state_d = ST_INT_OUT;
                        SYS_PRINT_STR: begin
                            fetch_load = 1'b1;
                            state_d    = ST_STR_REQ;
                        end
                        SYS_EXIT:      state_d = ST_HALTED;
`ifdef SYSCALL_PRINT_CHAR_EN
                        SYS_PRINT_CHAR: begin
                            // reuses the character output path, skipping memory
                            byte_d      = a0[7:0];
                            char_mode_d = 1'b1;
                            state_d     = ST_STR_OUT;
                        end
`endif
                        default:       state_d = ST_DONE;
                    endcase
                end
            end
            ST_INT_OUT: begin
                if (out_ready) state_d = ST_DONE;
            end
            ST_STR_REQ: begin
                if (str_end) state_d = ST_DONE;
                else         state_d = ST_STR_WAIT;
            end
            ST_STR_WAIT: begin
                if (str_end) begin
                    state_d = ST_DONE;
                end else if (byte_valid) begin
                    byte_d  = byte_data;
                    state_d = ST_STR_OUT;
                end
            end
            ST_STR_OUT: begin
                if (out_ready) begin
                    if (char_mode_q) begin
                        state_d = ST_DONE;
                    end else begin
                        fetch_advance = 1'b1;
                        state_d       = ST_STR_REQ;
                    end
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_kind  = KIND_INT;
        out_data  = '0;
        case (state_q)
            ST_INT_OUT: begin
                out_valid = 1'b1;
                out_data  = a0_q;
            end
            ST_STR_OUT: begin
                out_valid = 1'b1;
                out_kind  = KIND_CHAR;
                out_data  = zext_byte(byte_q);
            end
            default: ;
        endcase
    end

    // combinational so the pipeline freezes in the detect cycle itself
    assign stall        = (syscall_valid & (state_q == ST_IDLE)) |
                          ((state_q != ST_IDLE) & (state_q != ST_DONE));
    assign syscall_done = (state_q == ST_DONE);
    assign halt         = (state_q == ST_HALTED);

endmodule

// File: tb/tb_syscall_controller.sv
module tb_syscall_controller;

    localparam int MAX_STR = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        syscall_valid;
    logic [31:0] v0, a0;
    logic        stall, syscall_done, mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        out_valid, out_ready;
    logic [1:0]  out_kind;
    logic [31:0] out_data;
    logic        halt;

    syscall_controller #(.MAX_STR(MAX_STR)) dut (
        .clk           (clk),
        .rst           (rst),
        .syscall_valid (syscall_valid),
        .v0            (v0),
        .a0            (a0),
        .stall         (stall),
        .syscall_done  (syscall_done),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_kind      (out_kind),
        .out_data      (out_data),
        .halt          (halt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [33:0] exp_out[$];     // {kind, data}
    logic [31:0] exp_addr[$];
    logic [7:0]  mem[logic [31:0]];

    logic ready_force = 1'b0;
    logic ready_val   = 1'b1;
    int   lat_fixed   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd_mem(input logic [31:0] addr);
        if (mem.exists(addr)) return mem[addr];
        return 8'h5A;
    endfunction

    // Reference model: expected console items and memory addresses per service
    task automatic model_push(input logic [31:0] c, input logic [31:0] arg);
        if (c == 32'd1) begin
            exp_out.push_back({2'd0, arg});
        end else if (c == 32'd4) begin
            for (int i = 0; i < MAX_STR; i++) begin
                logic [31:0] ad;
                ad = arg + 32'(i);
                exp_addr.push_back(ad);
                if (rd_mem(ad) == 8'd0) break;
                exp_out.push_back({2'd1, 24'd0, rd_mem(ad)});
            end
        end
`ifdef SYSCALL_PRINT_CHAR_EN
        else if (c == 32'd11) begin
            exp_out.push_back({2'd1, 24'd0, arg[7:0]});
        end
`endif
    endtask

    // Console ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Console monitor / scoreboard
    initial begin : monitor
        logic        hold_prev;
        logic [31:0] prev_data;
        logic [1:0]  prev_kind;
        logic [33:0] e;
        hold_prev = 1'b0;
        prev_data = '0;
        prev_kind = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("out_valid_hold", {31'd0, out_valid}, 32'd1);
                    chk("out_data_hold", out_data, prev_data);
                    chk("out_kind_hold", {30'd0, out_kind}, {30'd0, prev_kind});
                end
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL out_unexpected: got kind %0d data 0x%08h, expected no output at %0t",
                                 out_kind, out_data, $time);
                    end else begin
                        e = exp_out.pop_front();
                        chk("out_kind", {30'd0, out_kind}, {30'd0, e[33:32]});
                        chk("out_data", out_data, e[31:0]);
                    end
                end
                hold_prev = out_valid && !out_ready;
                prev_data = out_data;
                prev_kind = out_kind;
            end
        end
    end

    // Data-memory responder with configurable latency
    initial begin : responder
        int          pend;
        int          lat;
        logic [31:0] req_addr;
        pend      = 0;
        lat       = 0;
        req_addr  = '0;
        mem_ack   = 1'b0;
        mem_rdata = 8'd0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (pend != 0) begin
                lat--;
                if (lat == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd_mem(req_addr);
                    pend      = 0;
                end
            end
            @(negedge clk);
            if (mem_ack) begin
                // data already returned this cycle
            end else if (pend == 0 && mem_req && !rst) begin
                pend     = 1;
                lat      = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
                req_addr = mem_addr;
                if (exp_addr.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL mem_req_unexpected: got addr 0x%08h, expected no request at %0t",
                             mem_addr, $time);
                end else begin
                    chk("mem_addr", mem_addr, exp_addr.pop_front());
                end
            end else if (pend != 0 && mem_req) begin
                chk("mem_addr_stable", mem_addr, req_addr);
            end
        end
    end

    task automatic check_reset_outputs();
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, syscall_done}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_kind", {30'd0, out_kind}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        syscall_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Issue one non-exit syscall and follow it to syscall_done
    task automatic run_syscall(input logic [31:0] c, input logic [31:0] arg,
                               input int hold, output int cyc);
        int   low;
        int   hcnt;
        logic got;
        @(posedge clk);
        #1;
        syscall_valid = 1'b1;
        v0 = c;
        a0 = arg;
        model_push(c, arg);
        @(negedge clk);
        chk("stall_detect", {31'd0, stall}, 32'd1);
        cyc  = 0;
        low  = 0;
        hcnt = 0;
        got  = 1'b0;
        while (cyc < 400 && !got) begin
            @(posedge clk);
            #1;
            v0 = $urandom;      // must be ignored after latch
            a0 = $urandom;
            @(negedge clk);
            cyc++;
            if (syscall_done) begin
                got = 1'b1;
                chk("stall_in_done", {31'd0, stall}, 32'd0);
            end else if (!stall) begin
                low++;
            end
            if (hold > 0 && out_valid && !out_ready) begin
                hcnt++;
                if (hcnt >= hold) ready_val = 1'b1;
            end
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("stall_busy", 32'(low), 32'd0);
        @(posedge clk);
        #1;
        syscall_valid = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", {31'd0, syscall_done}, 32'd0);
        chk("exp_out_left", 32'(exp_out.size()), 32'd0);
        chk("exp_addr_left", 32'(exp_addr.size()), 32'd0);
        exp_out.delete();
        exp_addr.delete();
    endtask

    task automatic fill_string(input logic [31:0] base, input int len);
        for (int i = 0; i < len; i++)
            mem[base + 32'(i)] = 8'($urandom_range(1, 255));
        mem[base + 32'(len)] = 8'd0;
    endtask

    initial begin : driver
        int          cyc;
        int          seen;
        logic [31:0] c, arg;
        rst = 1'b1;
        syscall_valid = 1'b0;
        v0 = '0;
        a0 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs();

        // Integer with console back-pressure
        ready_force = 1'b1;
        ready_val   = 1'b0;
        @(posedge clk);
        run_syscall(32'd1, 32'hFFFF_FFF6, 3, cyc);
        ready_val = 1'b1;
        @(posedge clk);

        // Integer latency with ready high
        run_syscall(32'd1, 32'h1234_5678, 0, cyc);
        chk("int_latency", 32'(cyc), 32'd2);

        // Unknown service
        run_syscall(32'd7, 32'hDEAD_BEEF, 0, cyc);
        chk("unknown_latency", 32'(cyc), 32'd1);

        // "Hi" at 0x100, memory latency 2
        mem.delete();
        mem[32'h100] = 8'h48;
        mem[32'h101] = 8'h69;
        mem[32'h102] = 8'h00;
        lat_fixed = 2;
        run_syscall(32'd4, 32'h100, 0, cyc);

        // 3-byte string, latency 1: 3 cycles/byte + 2 for NUL, then DONE
        mem.delete();
        fill_string(32'h2000, 3);
        lat_fixed = 1;
        run_syscall(32'd4, 32'h2000, 0, cyc);
        chk("str3_latency", 32'(cyc), 32'd12);

        // Empty string
        mem.delete();
        fill_string(32'h3000, 0);
        run_syscall(32'd4, 32'h3000, 0, cyc);
        chk("empty_latency", 32'(cyc), 32'd3);

        // Truncation at MAX_STR with address wrap
        mem.delete();
        lat_fixed = 0;
        ready_force = 1'b0;
        run_syscall(32'd4, 32'hFFFF_FFFE, 0, cyc);

        // Print character (enabled or unknown, depending on build)
        run_syscall(32'd11, 32'h41, 0, cyc);

        // Randomized mix
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0:       c = 32'd1;
                1, 2:    c = 32'd4;
                3:       c = 32'd11;
                4:       c = 32'd7;
                default: begin
                    c = $urandom;
                    if (c == 32'd1 || c == 32'd4 || c == 32'd10 || c == 32'd11) c = 32'd3;
                end
            endcase
            arg = $urandom;
            if (c == 32'd4) begin
                mem.delete();
                fill_string(arg, $urandom_range(0, 6));
            end
            run_syscall(c, arg, 0, cyc);
        end

        // Reset while awaiting mem_ack; the late ack must be ignored
        mem.delete();
        lat_fixed   = 6;
        ready_force = 1'b1;
        ready_val   = 1'b1;
        @(posedge clk);
        #1;
        syscall_valid = 1'b1;
        v0 = 32'd4;
        a0 = 32'h4000;
        model_push(32'd4, 32'h4000);
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (mem_req) seen = 1;
        end
        chk("midrst_req_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        syscall_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_out.delete();
        exp_addr.delete();
        @(negedge clk);
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid || mem_req || syscall_done) seen++;
        end
        chk("late_ack_quiet", 32'(seen), 32'd0);
        lat_fixed = 0;

        // Exit
        @(posedge clk);
        #1;
        syscall_valid = 1'b1;
        v0 = 32'd10;
        a0 = $urandom;
        @(negedge clk);
        chk("exit_stall_detect", {31'd0, stall}, 32'd1);
        chk("exit_halt_detect", {31'd0, halt}, 32'd0);
        @(posedge clk);
        #1;
        syscall_valid = 1'b0;
        v0 = 32'd1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!halt || !stall || syscall_done || out_valid || mem_req) seen++;
        end
        chk("halted_held", 32'(seen), 32'd0);
        do_reset();
        check_reset_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
